// File: rtl/wbu_writeback_stage.sv
// Write-back stage: single-entry pipeline register between MEM and the RV32E
// GPR file. Result selection and load alignment happen at capture; the held
// entry drives the GPR write port for one cycle when it commits.
module wbu_writeback_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_GPR = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_valid,
    output logic             WBU_ready,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_RegWr,
    input  logic [1:0]       MEM_wb_sel,
    input  logic [XLEN-1:0]  MEM_alu_result,
    input  logic [XLEN-1:0]  MEM_load_word,
    input  logic [2:0]       MEM_funct3,
    input  logic [XLEN-1:0]  MEM_pc,
    input  logic [XLEN-1:0]  MEM_csr_rdata,
    input  logic             commit_halt,
    output logic [4:0]       WBU_rd,
    output logic             RegWr,
    output logic [XLEN-1:0]  rf_busW,
    output logic             WBU_commit,
    output logic [XLEN-1:0]  WBU_commit_pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             WBU_err,
    output logic [1:0]       WBU_err_cause
);

    typedef enum logic {EMPTY, FULL} state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_RD       = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_FUNCT3   = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_PC4  = 2'b10,
        SEL_CSR  = 2'b11
    } wb_sel_t;

    state_t          state;
    state_t          state_next;
    logic [4:0]      hold_rd;
    logic            hold_regwr;
    logic [XLEN-1:0] hold_data;
    logic [XLEN-1:0] hold_pc;
    err_t            hold_err;

    logic            transfer;
    logic            commit;
    logic [1:0]      off;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] cap_data;
    err_t            cap_err;

    assign off      = MEM_alu_result[1:0];
    assign byte_val = MEM_load_word[8*off +: 8];
    assign half_val = MEM_load_word[16*off[1] +: 16];

    // Select and align the incoming result and classify any error at capture
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // statements leaves it unassigned and infers a latch.
        load_val = '0;
        cap_data = '0;
        cap_err  = ERR_NONE;

        case (MEM_funct3)
            3'b000:  load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_val};
            3'b001:  load_val = {{(XLEN-16){half_val[15]}}, half_val};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_val};
            3'b010:  load_val = MEM_load_word;
            default: load_val = '0;
        endcase

        case (wb_sel_t'(MEM_wb_sel))
            SEL_ALU:  cap_data = MEM_alu_result;
            SEL_LOAD: cap_data = load_val;
            SEL_PC4:  cap_data = MEM_pc + XLEN'(4);
            SEL_CSR:  cap_data = MEM_csr_rdata;
            default:  cap_data = '0;
        endcase

        // A bad funct3 makes alignment meaningless, so it wins over misalignment;
        // load errors win over an illegal destination.
        if (MEM_wb_sel == SEL_LOAD &&
            (MEM_funct3 == 3'b011 || MEM_funct3 == 3'b110 || MEM_funct3 == 3'b111)) begin
            cap_err = ERR_FUNCT3;
        end else if (MEM_wb_sel == SEL_LOAD &&
                     (((MEM_funct3[1:0] == 2'b01) && off[0]) ||
                      ((MEM_funct3[1:0] == 2'b10) && (off != 2'b00)))) begin
            cap_err = ERR_MISALIGN;
        end else if (MEM_RegWr && (int'(MEM_rd) >= NUM_GPR)) begin
            cap_err = ERR_RD;
        end
    end

    // Next-state, handshake and commit decode from the held entry
    always_comb begin
        state_next = state;
        WBU_ready  = 1'b0;
        commit     = 1'b0;
        RegWr      = 1'b0;

        if (!rst) begin
            WBU_ready = (state == EMPTY) || !commit_halt;
            commit    = (state == FULL) && !commit_halt;
            RegWr     = commit && hold_regwr && (hold_rd != 5'd0) && (hold_err == ERR_NONE);
        end

        case (state)
            EMPTY:   if (transfer) state_next = FULL;
            FULL:    if (!commit_halt && !transfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign transfer      = MEM_valid && WBU_ready;
    assign WBU_commit    = commit;
    assign WBU_rd        = hold_rd;
    assign rf_busW       = hold_data;
    assign WBU_commit_pc = hold_pc;

    // State register, pipeline register capture, retire counter and sticky error
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples values from before this edge, regardless of statement order.
        if (rst) begin
            // NOTE: the pipeline register is reset too, because its contents are
            // visible on WBU_rd/rf_busW/WBU_commit_pc and must read zero after reset.
            state         <= EMPTY;
            hold_rd       <= '0;
            hold_regwr    <= 1'b0;
            hold_data     <= '0;
            hold_pc       <= '0;
            hold_err      <= ERR_NONE;
            retire_cnt    <= '0;
            WBU_err       <= 1'b0;
            WBU_err_cause <= 2'b00;
        end else begin
            state <= state_next;
            if (transfer) begin
                hold_rd    <= MEM_rd;
                hold_regwr <= MEM_RegWr;
                hold_data  <= cap_data;
                hold_pc    <= MEM_pc;
                hold_err   <= cap_err;
            end
            if (commit) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (!WBU_err && hold_err != ERR_NONE) begin
                    WBU_err       <= 1'b1;
                    WBU_err_cause <= hold_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_wbu_writeback_stage.sv
// Self-checking bench for wbu_writeback_stage: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_wbu_writeback_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        regwr;
        logic [1:0]  wb_sel;
        logic [31:0] alu;
        logic [31:0] word;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] csr;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_valid = 1'b0;
    logic        WBU_ready;
    logic [4:0]  MEM_rd = '0;
    logic        MEM_RegWr = 1'b0;
    logic [1:0]  MEM_wb_sel = '0;
    logic [31:0] MEM_alu_result = '0;
    logic [31:0] MEM_load_word = '0;
    logic [2:0]  MEM_funct3 = '0;
    logic [31:0] MEM_pc = '0;
    logic [31:0] MEM_csr_rdata = '0;
    logic        commit_halt = 1'b0;
    logic [4:0]  WBU_rd;
    logic        RegWr;
    logic [31:0] rf_busW;
    logic        WBU_commit;
    logic [31:0] WBU_commit_pc;
    logic [31:0] retire_cnt;
    logic        WBU_err;
    logic [1:0]  WBU_err_cause;

    wbu_writeback_stage dut (
        .clk(clk), .rst(rst),
        .MEM_valid(MEM_valid), .WBU_ready(WBU_ready),
        .MEM_rd(MEM_rd), .MEM_RegWr(MEM_RegWr), .MEM_wb_sel(MEM_wb_sel),
        .MEM_alu_result(MEM_alu_result), .MEM_load_word(MEM_load_word),
        .MEM_funct3(MEM_funct3), .MEM_pc(MEM_pc), .MEM_csr_rdata(MEM_csr_rdata),
        .commit_halt(commit_halt),
        .WBU_rd(WBU_rd), .RegWr(RegWr), .rf_busW(rf_busW),
        .WBU_commit(WBU_commit), .WBU_commit_pc(WBU_commit_pc),
        .retire_cnt(retire_cnt), .WBU_err(WBU_err), .WBU_err_cause(WBU_err_cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        m_full = 1'b0;
    txn_t        m_txn  = '0;
    logic [31:0] m_cnt  = '0;
    logic        m_err  = 1'b0;
    logic [1:0]  m_cause = '0;

    // Observations from the most recent cycle, for directed literal checks
    logic        last_ready, last_regwr, last_commit, last_err;
    logic [4:0]  last_rd;
    logic [31:0] last_busw, last_cnt;
    logic [1:0]  last_cause;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic txn_t mk(input logic [4:0] rd, input logic regwr, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [31:0] word,
                                input logic [2:0] f3, input logic [31:0] pc);
        txn_t t;
        t.valid = 1'b1; t.rd = rd; t.regwr = regwr; t.wb_sel = sel;
        t.alu = alu; t.word = word; t.f3 = f3; t.pc = pc; t.csr = 32'hC5C5_0000 | 32'(rd);
        return t;
    endfunction

    function automatic txn_t idle();
        txn_t t = '0;
        return t;
    endfunction

    // Value written back for a transaction, from the architectural rules
    function automatic logic [31:0] model_data(input txn_t t);
        int unsigned off = t.alu % 4;
        logic [31:0] v = '0;
        case (t.wb_sel)
            2'd0: v = t.alu;
            2'd2: v = t.pc + 32'd4;
            2'd3: v = t.csr;
            default: begin
                if (t.f3 == 3'd0 || t.f3 == 3'd4) begin
                    v = (t.word >> (8 * off)) % 256;
                    if (t.f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
                end else if (t.f3 == 3'd1 || t.f3 == 3'd5) begin
                    v = (t.word >> (16 * (off / 2))) % 65536;
                    if (t.f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
                end else if (t.f3 == 3'd2) begin
                    v = t.word;
                end
            end
        endcase
        return v;
    endfunction

    function automatic logic [1:0] model_err(input txn_t t);
        int unsigned off = t.alu % 4;
        if (t.wb_sel == 2'd1) begin
            if (t.f3 == 3'd3 || t.f3 == 3'd6 || t.f3 == 3'd7) return 2'b11;
            if ((t.f3 % 4 == 1 && off % 2 != 0) || (t.f3 == 3'd2 && off != 0)) return 2'b10;
        end
        if (t.regwr && t.rd >= 16) return 2'b01;
        return 2'b00;
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model
    task automatic cycle(input txn_t t, input logic halt);
        logic exp_ready, exp_commit, exp_wr;
        logic [1:0] e;
        @(negedge clk);
        MEM_valid = t.valid; MEM_rd = t.rd; MEM_RegWr = t.regwr; MEM_wb_sel = t.wb_sel;
        MEM_alu_result = t.alu; MEM_load_word = t.word; MEM_funct3 = t.f3;
        MEM_pc = t.pc; MEM_csr_rdata = t.csr; commit_halt = halt;
        #1;
        exp_ready  = !m_full || !halt;
        exp_commit = m_full && !halt;
        e          = model_err(m_txn);
        exp_wr     = exp_commit && m_txn.regwr && m_txn.rd != 0 && e == 2'b00;
        check("ready", 32'(WBU_ready), 32'(exp_ready));
        check("commit", 32'(WBU_commit), 32'(exp_commit));
        check("regwr", 32'(RegWr), 32'(exp_wr));
        if (exp_wr) begin
            check("wr_rd", 32'(WBU_rd), 32'(m_txn.rd));
            check("wr_data", rf_busW, model_data(m_txn));
        end
        if (exp_commit) check("commit_pc", WBU_commit_pc, m_txn.pc);
        check("retire_cnt", retire_cnt, m_cnt);
        check("err", 32'(WBU_err), 32'(m_err));
        check("cause", 32'(WBU_err_cause), 32'(m_cause));
        last_ready = WBU_ready; last_regwr = RegWr; last_commit = WBU_commit;
        last_rd = WBU_rd; last_busw = rf_busW; last_cnt = retire_cnt;
        last_err = WBU_err; last_cause = WBU_err_cause;
        if (exp_commit) begin
            m_cnt = m_cnt + 32'd1;
            if (!m_err && e != 2'b00) begin
                m_err = 1'b1; m_cause = e;
            end
        end
        if (t.valid && exp_ready) begin
            m_full = 1'b1; m_txn = t;
        end else if (exp_commit) begin
            m_full = 1'b0;
        end
    endtask

    // Reset for one cycle (possibly while FULL) and verify reset values afterwards
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; MEM_valid = 1'b1; commit_halt = 1'b0;
        #1;
        check("rst_cycle_regwr", 32'(RegWr), 32'd0);
        check("rst_cycle_commit", 32'(WBU_commit), 32'd0);
        @(negedge clk);
        rst = 1'b0; MEM_valid = 1'b0;
        #1;
        check("rst_ready", 32'(WBU_ready), 32'd1);
        check("rst_regwr", 32'(RegWr), 32'd0);
        check("rst_commit", 32'(WBU_commit), 32'd0);
        check("rst_rd", 32'(WBU_rd), 32'd0);
        check("rst_busw", rf_busW, 32'd0);
        check("rst_pc", WBU_commit_pc, 32'd0);
        check("rst_cnt", retire_cnt, 32'd0);
        check("rst_err", 32'(WBU_err), 32'd0);
        check("rst_cause", 32'(WBU_err_cause), 32'd0);
        m_full = 1'b0; m_txn = '0; m_cnt = '0; m_err = 1'b0; m_cause = '0;
    endtask

    initial begin
        txn_t t;

        // Basic ALU write
        do_reset();
        cycle(mk(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 3'd0, 32'h100), 1'b0);
        cycle(idle(), 1'b0);
        check("basic_regwr", 32'(last_regwr), 32'd1);
        check("basic_rd", 32'(last_rd), 32'd5);
        check("basic_data", last_busw, 32'h0000_1234);
        check("basic_cnt_before", last_cnt, 32'd0);
        cycle(idle(), 1'b0);
        check("basic_cnt_after", last_cnt, 32'd1);

        // Byte / half load alignment and extension
        cycle(mk(5'd6, 1'b1, 2'b01, 32'h2003, 32'h80FF_0000, 3'b000, 32'h104), 1'b0);
        cycle(mk(5'd7, 1'b1, 2'b01, 32'h2003, 32'h80FF_0000, 3'b100, 32'h108), 1'b0);
        check("lb_sext", last_busw, 32'hFFFF_FF80);
        cycle(mk(5'd8, 1'b1, 2'b01, 32'h2002, 32'h80FF_0000, 3'b001, 32'h10C), 1'b0);
        check("lbu_zext", last_busw, 32'h0000_0080);
        cycle(idle(), 1'b0);
        check("lh_sext", last_busw, 32'hFFFF_80FF);

        // Back-to-back throughput
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(mk(5'(i), 1'b1, 2'b00, 32'(i * 16), 32'h0, 3'd0, 32'(i * 4)), 1'b0);
            check("b2b_ready", 32'(last_ready), 32'd1);
            if (i > 1) check("b2b_rd", 32'(last_rd), 32'(i - 1));
        end
        cycle(idle(), 1'b0);
        check("b2b_rd_last", 32'(last_rd), 32'd4);
        cycle(idle(), 1'b0);
        check("b2b_cnt", last_cnt, 32'd4);

        // Commit halt holds the entry
        do_reset();
        cycle(mk(5'd9, 1'b1, 2'b00, 32'hAB, 32'h0, 3'd0, 32'h200), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(idle(), 1'b1);
            check("halt_regwr", 32'(last_regwr), 32'd0);
            check("halt_ready", 32'(last_ready), 32'd0);
        end
        cycle(idle(), 1'b0);
        check("halt_release_wr", 32'(last_regwr), 32'd1);
        check("halt_release_data", last_busw, 32'hAB);
        cycle(idle(), 1'b0);
        check("halt_single_wr", 32'(last_regwr), 32'd0);
        check("halt_cnt", last_cnt, 32'd1);

        // Misaligned lw, then illegal rd; cause keeps the first error
        do_reset();
        cycle(mk(5'd7, 1'b1, 2'b01, 32'h1002, 32'hDEAD_BEEF, 3'b010, 32'h300), 1'b0);
        cycle(mk(5'd20, 1'b1, 2'b00, 32'h55, 32'h0, 3'd0, 32'h304), 1'b0);
        check("mis_regwr", 32'(last_regwr), 32'd0);
        check("mis_commit", 32'(last_commit), 32'd1);
        cycle(idle(), 1'b0);
        check("mis_err", 32'(last_err), 32'd1);
        check("mis_cause", 32'(last_cause), 32'd2);
        check("rd20_regwr", 32'(last_regwr), 32'd0);
        cycle(idle(), 1'b0);
        check("cause_sticky", 32'(last_cause), 32'd2);

        // PC+4 wrap and rd=0
        do_reset();
        cycle(mk(5'd3, 1'b1, 2'b10, 32'h0, 32'h0, 3'd0, 32'hFFFF_FFFC), 1'b0);
        cycle(mk(5'd0, 1'b1, 2'b00, 32'h77, 32'h0, 3'd0, 32'h0), 1'b0);
        check("pc4_wrap", last_busw, 32'h0000_0000);
        check("pc4_regwr", 32'(last_regwr), 32'd1);
        cycle(idle(), 1'b0);
        check("rd0_regwr", 32'(last_regwr), 32'd0);
        check("rd0_commit", 32'(last_commit), 32'd1);
        cycle(idle(), 1'b0);
        check("rd0_no_err", 32'(last_err), 32'd0);

        // Reset while FULL
        cycle(mk(5'd4, 1'b1, 2'b00, 32'h99, 32'h0, 3'd0, 32'h400), 1'b0);
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            t.valid  = ($urandom_range(3) != 0);
            t.rd     = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 16)) : 5'($urandom_range(15));
            t.regwr  = ($urandom_range(4) != 0);
            t.wb_sel = 2'($urandom_range(3));
            t.alu    = $urandom;
            t.word   = $urandom;
            t.f3     = ($urandom_range(9) == 0) ? 3'($urandom_range(7))
                                                : ((($urandom_range(1) == 1) ? 3'b100 : 3'b000) |
                                                   3'($urandom_range(2)));
            t.pc     = $urandom;
            t.csr    = $urandom;
            cycle(t, ($urandom_range(3) == 0));
        end
        cycle(idle(), 1'b0);
        cycle(idle(), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wbu_writeback_stage.md
Name: wbu_writeback_stage

Overview:
- Write-back stage directly upstream of the RV32E GPR file.
- Accepts one retiring instruction per cycle from the MEM stage over a valid/ready handshake and holds it in a single-entry pipeline register.
- Selects and aligns the result, then drives the GPR write port (WBU_rd, RegWr, rf_busW) for exactly one cycle per instruction.
- Also reports commit, commit PC and a retired-instruction count, and flags bad destinations and bad loads.

Parameters:
- XLEN, 32, data path width.
- NUM_GPR, 16, number of architectural registers; RV32E, so rd >= 16 is illegal.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- MEM_valid  input  1  MEM stage presents an instruction
- WBU_ready  output  1  stage can accept this cycle
- MEM_rd  input  5  destination register index
- MEM_RegWr  input  1  instruction writes a GPR
- MEM_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR
- MEM_alu_result  input  32  ALU result; for loads, the effective address
- MEM_load_word  input  32  raw aligned word returned by memory
- MEM_funct3  input  3  load size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- MEM_pc  input  32  PC of the instruction
- MEM_csr_rdata  input  32  CSR read data
- commit_halt  input  1  debug/difftest hold; freezes commit
- WBU_rd  output  5  GPR write index
- RegWr  output  1  GPR write enable
- rf_busW  output  32  GPR write data
- WBU_commit  output  1  one-cycle pulse per retired instruction
- WBU_commit_pc  output  32  PC of the committing instruction
- retire_cnt  output  CNT_W  count of retired instructions
- WBU_err  output  1  sticky error flag
- WBU_err_cause  output  2  01 illegal rd, 10 misaligned load, 11 bad load funct3

Behaviour:
- Reset:
  - Entry is empty.
  - RegWr=0, WBU_commit=0, WBU_rd=0, rf_busW=0, WBU_commit_pc=0.
  - retire_cnt=0, WBU_err=0, WBU_err_cause=0.
  - WBU_ready=1 from the first cycle after reset.
  - Reset mid-operation discards the held entry; no write occurs in the reset cycle.
- States: EMPTY, FULL.
- Handshake:
  - A transfer occurs when MEM_valid && WBU_ready at a rising edge.
  - WBU_ready = EMPTY || (FULL && !commit_halt).
  - Capture and commit of the previous entry may occur in the same cycle (back-to-back, throughput 1/cycle).
- Transitions:
  - EMPTY + transfer -> FULL.
  - FULL + !commit_halt + transfer -> FULL with the new entry.
  - FULL + !commit_halt + no transfer -> EMPTY.
  - FULL + commit_halt -> FULL, entry held unchanged.
- Commit is combinational from the held register while FULL && !commit_halt:
  - WBU_commit=1 and WBU_commit_pc=held PC.
  - RegWr=held RegWr && rd!=0 && rd<NUM_GPR && no load error.
  - retire_cnt increments at that edge and wraps 0xFFFFFFFF -> 0.
  - Outside a commit, RegWr=0 and WBU_commit=0; WBU_rd/rf_busW may show held values.
- Latency: capture at edge N; RegWr is visible in cycle N+1; the GPR updates at edge N+1.
- Result mux (computed at capture, stored in the register):
  - ALU -> alu_result.
  - PC+4 -> pc+32'd4 (mod 2^32).
  - CSR -> csr_rdata.
- Load alignment, with off = alu_result[1:0]:
  - Byte = word[8*off +: 8], sign- or zero-extended by funct3.
  - Half = word[16*off[1] +: 16]; requires off[0]=0.
  - lw requires off=0.
- Errors (load errors are checked only when wb_sel=01):
  - Misaligned load -> cause 10.
  - funct3 in {011,110,111} -> cause 11.
  - rd>=16 with RegWr -> cause 01.
  - Any error suppresses RegWr, but the instruction still commits and counts.
  - WBU_err is set at commit and is sticky until reset; cause records the first error only.
- rd=0 with RegWr: no write, no error.

Test Plan:
- Reset then MEM_valid with rd=5, wb_sel=00, alu=0x1234 -> next cycle RegWr=1, WBU_rd=5, rf_busW=0x00001234, WBU_commit=1, retire_cnt 0->1.
- lb with off=3 on word 0x80FF_0000 -> rf_busW=0xFFFFFF80; lbu, same stimulus -> 0x00000080; lh with off=2 -> 0xFFFF80FF.
- Four back-to-back valid cycles with rd=1..4 -> WBU_ready stays 1; four consecutive RegWr pulses in order; retire_cnt=4.
- FULL entry held with commit_halt=1 for 3 cycles -> RegWr=0, WBU_ready=0, entry unchanged; halt released -> single write.
- lw with alu=0x1002, rd=7 -> RegWr=0, WBU_commit=1, WBU_err=1, cause=10; a following rd=20 write -> RegWr=0, cause stays 10.
- wb_sel=10, pc=0xFFFFFFFC -> rf_busW=0x00000000.
- rd=0 write -> RegWr=0, no error.
- rst asserted while FULL -> no write that cycle; all outputs at reset values.
